// File: rtl/gf180mcu_fd_io__pwr_seq.sv
`timescale 1ns/1ps
// gf180mcu_fd_io__pwr_seq
// Qualifies the DVDD supply-present indication and sequences the IO bank
// enables: thermometer ramp-up after debounce, reverse ramp-down on request,
// and an immediate drop of all enables when the supply is lost.
// Ports:
//   clk        core clock
//   rn         asynchronous active-low reset
//   supply_ok  raw DVDD-present indication, asynchronous to clk
//   req_off    level; orderly shutdown request / hold off power-up
//   clr_fault  single-cycle pulse; clears fault_sts
//   bank_en    per-bank enable, bit 0 powers up first (thermometer code)
//   pwr_good   all banks on and supply qualified
//   fault_sts  sticky; supply lost while any bank was enabled
//   state      debug view of the sequencer state
module gf180mcu_fd_io__pwr_seq #(
  parameter int unsigned NBANKS      = 4,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rn,
  input  logic              supply_ok,
  input  logic              req_off,
  input  logic              clr_fault,
  output logic [NBANKS-1:0] bank_en,
  output logic              pwr_good,
  output logic              fault_sts,
  output logic [2:0]        state
);

  localparam int unsigned MAX_AB = (DEB_CYCLES > STEP_CYCLES) ? DEB_CYCLES : STEP_CYCLES;
  localparam int unsigned MAX_C  = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
  localparam int unsigned CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DEB   = 3'd1,
    ST_RUP   = 3'd2,
    ST_ON    = 3'd3,
    ST_RDN   = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [NBANKS-1:0]  bank_n;
  logic               pg_n;
  logic               fault_n;
  logic               fault_set;
  logic               sync1, sok;

  // Two-flop synchronizer for the asynchronous supply indication
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      sync1 <= 1'b0;
      sok   <= 1'b0;
    end else begin
      sync1 <= supply_ok;
      sok   <= sync1;
    end
  end

  // State, shared counter and registered outputs
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      bank_en   <= '0;
      pwr_good  <= 1'b0;
      fault_sts <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      bank_en   <= bank_n;
      pwr_good  <= pg_n;
      fault_sts <= fault_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    bank_n    = bank_en;
    pg_n      = pwr_good;
    fault_set = 1'b0;

    case (state_q)
      ST_OFF: begin
        bank_n = '0;
        pg_n   = 1'b0;
        cnt_n  = '0;
        if (sok && !req_off) begin
          state_n = ST_DEB;
        end
      end

      ST_DEB: begin
        if (!sok || req_off) begin
          state_n = ST_OFF;
          cnt_n   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_n = ST_RUP;
          bank_n  = NBANKS'(1);
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_RUP, ST_ON, ST_RDN: begin
        // Supply loss outranks everything, including an orderly shutdown
        if (!sok) begin
          state_n   = ST_FAULT;
          bank_n    = '0;
          pg_n      = 1'b0;
          cnt_n     = '0;
          fault_set = 1'b1;
        end else if (state_q == ST_RDN) begin
          if (cnt_q == STEP_LAST) begin
            cnt_n  = '0;
            bank_n = bank_en >> 1;
            if ((bank_en >> 1) == '0) begin
              state_n = ST_OFF;
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end else if (req_off) begin
          state_n = ST_RDN;
          pg_n    = 1'b0;
          cnt_n   = '0;
        end else if (state_q == ST_ON) begin
          pg_n   = 1'b1;
          bank_n = '1;
        end else if (cnt_q == STEP_LAST) begin
          cnt_n = '0;
          if (bank_en[NBANKS-1]) begin
            state_n = ST_ON;
            pg_n    = 1'b1;
          end else begin
            bank_n = NBANKS'({bank_en, 1'b1});
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_FAULT: begin
        bank_n = '0;
        pg_n   = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          state_n = ST_OFF;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_n = ST_OFF;
        bank_n  = '0;
        pg_n    = 1'b0;
        cnt_n   = '0;
      end
    endcase

    // Sticky fault flag; a new fault wins over a simultaneous clear
    if (fault_set) begin
      fault_n = 1'b1;
    end else if (clr_fault) begin
      fault_n = 1'b0;
    end else begin
      fault_n = fault_sts;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_gf180mcu_fd_io__pwr_seq.sv
`timescale 1ns/1ps
module tb_gf180mcu_fd_io__pwr_seq;

  localparam int NB   = 4;
  localparam int DEB  = 4;
  localparam int STEP = 8;
  localparam int HOLD = 16;

  logic          clk = 1'b0;
  logic          rn;
  logic          supply_ok;
  logic          req_off;
  logic          clr_fault;
  logic [NB-1:0] bank_en;
  logic          pwr_good;
  logic          fault_sts;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  gf180mcu_fd_io__pwr_seq #(
    .NBANKS(NB), .DEB_CYCLES(DEB), .STEP_CYCLES(STEP), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rn(rn), .supply_ok(supply_ok), .req_off(req_off),
    .clr_fault(clr_fault), .bank_en(bank_en), .pwr_good(pwr_good),
    .fault_sts(fault_sts), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: phase, edges elapsed in the phase, number of banks on
  localparam int P_OFF = 0, P_DEB = 1, P_RUP = 2, P_ON = 3, P_RDN = 4, P_FAULT = 5;
  int m_phase, m_t, m_nb;
  bit m_fault, m_s1, m_s2;

  function automatic void model_reset();
    m_phase = P_OFF; m_t = 0; m_nb = 0; m_fault = 0; m_s1 = 0; m_s2 = 0;
  endfunction

  function automatic void model_edge(bit so, bit req, bit clr);
    bit sok = m_s2;
    bit fset = 0;
    m_s2 = m_s1;
    m_s1 = so;
    case (m_phase)
      P_OFF: if (sok && !req) begin m_phase = P_DEB; m_t = 0; end
      P_DEB: begin
        if (!sok || req) m_phase = P_OFF;
        else begin
          m_t++;
          if (m_t == DEB) begin m_phase = P_RUP; m_nb = 1; m_t = 0; end
        end
      end
      P_RUP, P_ON, P_RDN: begin
        if (!sok) begin
          m_phase = P_FAULT; m_nb = 0; m_t = 0; fset = 1;
        end else if (m_phase == P_RDN) begin
          m_t++;
          if (m_t == STEP) begin
            m_t = 0; m_nb--;
            if (m_nb == 0) m_phase = P_OFF;
          end
        end else if (req) begin
          m_phase = P_RDN; m_t = 0;
        end else if (m_phase == P_RUP) begin
          m_t++;
          if (m_t == STEP) begin
            m_t = 0;
            if (m_nb == NB) m_phase = P_ON;
            else m_nb++;
          end
        end
      end
      default: begin
        m_t++;
        if (m_t == HOLD) begin m_phase = P_OFF; m_t = 0; end
      end
    endcase
    if (fset) m_fault = 1;
    else if (clr) m_fault = 0;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock edge: advance the model, then compare the DUT away from the edge
  task automatic tick();
    logic [NB-1:0] eb;
    @(posedge clk);
    model_edge(supply_ok, req_off, clr_fault);
    #1;
    eb = NB'((1 << m_nb) - 1);
    check("model_bank_en", 32'(bank_en), 32'(eb));
    check("model_pwr_good", 32'(pwr_good), 32'(m_phase == P_ON));
    check("model_fault_sts", 32'(fault_sts), 32'(m_fault));
    check("model_state", 32'(state), 32'(m_phase));
  endtask

  typedef struct {
    bit          so, req, clr;
    int          n;
    logic [3:0]  bank;
    bit          pg, flt;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rn = 1'b0; supply_ok = 1'b0; req_off = 1'b0; clr_fault = 1'b0;
    model_reset();

    vecs = '{
      // power-up
      '{1,0,0,6, 4'h0,0,0,3'd1}, '{1,0,0,1, 4'h1,0,0,3'd2}, '{1,0,0,7, 4'h1,0,0,3'd2},
      '{1,0,0,1, 4'h3,0,0,3'd2}, '{1,0,0,8, 4'h7,0,0,3'd2}, '{1,0,0,8, 4'hF,0,0,3'd2},
      '{1,0,0,7, 4'hF,0,0,3'd2}, '{1,0,0,1, 4'hF,1,0,3'd3},
      // orderly off (req_off dropped mid ramp-down does not abort it)
      '{1,1,0,1, 4'hF,0,0,3'd4}, '{1,1,0,7, 4'hF,0,0,3'd4}, '{1,1,0,1, 4'h7,0,0,3'd4},
      '{1,0,0,8, 4'h3,0,0,3'd4}, '{1,1,0,8, 4'h1,0,0,3'd4}, '{1,1,0,8, 4'h0,0,0,3'd0},
      '{1,1,0,10,4'h0,0,0,3'd0},
      // glitch shorter than the debounce
      '{0,1,0,3, 4'h0,0,0,3'd0}, '{1,0,0,3, 4'h0,0,0,3'd1}, '{0,0,0,2, 4'h0,0,0,3'd1},
      '{0,0,0,1, 4'h0,0,0,3'd0}, '{0,0,0,5, 4'h0,0,0,3'd0},
      // supply loss in ON; clear on the entry edge loses
      '{1,0,0,39,4'hF,1,0,3'd3}, '{0,0,0,2, 4'hF,1,0,3'd3}, '{0,0,1,1, 4'h0,0,1,3'd5},
      '{0,0,0,15,4'h0,0,1,3'd5}, '{0,0,0,1, 4'h0,0,1,3'd0}, '{0,0,1,1, 4'h0,0,0,3'd0},
      // abort ramp-up at 0011
      '{1,0,0,15,4'h3,0,0,3'd2}, '{1,1,0,1, 4'h3,0,0,3'd4}, '{1,1,0,8, 4'h1,0,0,3'd4},
      '{1,1,0,8, 4'h0,0,0,3'd0}
    };

    repeat (3) @(posedge clk);
    #1;
    check("reset_bank_en", 32'(bank_en), 32'h0);
    check("reset_pwr_good", 32'(pwr_good), 32'h0);
    check("reset_fault_sts", 32'(fault_sts), 32'h0);
    check("reset_state", 32'(state), 32'h0);
    rn = 1'b1;

    foreach (vecs[i]) begin
      supply_ok = vecs[i].so; req_off = vecs[i].req; clr_fault = vecs[i].clr;
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d_bank_en", i), 32'(bank_en), 32'(vecs[i].bank));
      check($sformatf("vec%0d_pwr_good", i), 32'(pwr_good), 32'(vecs[i].pg));
      check($sformatf("vec%0d_fault_sts", i), 32'(fault_sts), 32'(vecs[i].flt));
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
    end
    clr_fault = 1'b0; req_off = 1'b0;

    // Asynchronous reset while in ON, checked before the next clock edge
    supply_ok = 1'b0;
    repeat (3) tick();
    supply_ok = 1'b1;
    repeat (39) tick();
    check("pre_reset_on_state", 32'(state), 32'd3);
    #3 rn = 1'b0;
    #1;
    check("async_rst_bank_en", 32'(bank_en), 32'h0);
    check("async_rst_pwr_good", 32'(pwr_good), 32'h0);
    check("async_rst_fault_sts", 32'(fault_sts), 32'h0);
    check("async_rst_state", 32'(state), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rn = 1'b1;
    // Fresh debounce after release, supply still present
    repeat (6) tick();
    check("post_rst_deb_bank", 32'(bank_en), 32'h0);
    tick();
    check("post_rst_first_bank", 32'(bank_en), 32'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) supply_ok = ~supply_ok;
      if ($urandom_range(0, 99) == 0) req_off = ~req_off;
      clr_fault = ($urandom_range(0, 19) == 0);
      tick();
      if (pwr_good) check("inv_pg_all_on", 32'(bank_en), 32'hF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
